queue_drain_tx: RTL and testbench
=================================

// Module: queue_drain_tx
// PURPOSE
//   Consumer end of the Queue read interface: watches the Queue's empty flag,
//   issues one-cycle read strobes (RW=1, En=1), and captures each popped byte.
//   Each byte is sent on a serial line as an async frame, LSB first:
//   start, 8 data bits, optional even parity, stop.
//   Sits between Queue data_o/empty_o and the chip's serial TX pin.
// PARAMETERS
//   CLKS_PER_BIT  16  Clk_i cycles per serial bit; legal range >= 2.
//   PARITY_EN     0   1 = insert even-parity bit after D7; 0 = no parity bit.
//   DATA_W        8   Byte width; must match the Queue data width.
// PORTS
//   Clk_i       in   1       System clock; all logic on the rising edge.
//   Rst_i       in   1       Synchronous, active-high reset.
//   Tx_En_i     in   1       1 = allowed to start new frames.
//   q_empty_i   in   1       Queue empty_o.
//   q_data_i    in   DATA_W  Queue data_o. Valid the cycle after the read strobe.
//   q_RW_o      out  1       To Queue RW_i; 1 (read) only while q_En_o=1, else 0.
//   q_En_o      out  1       To Queue En_i; single-cycle read strobe.
//   tx_o        out  1       Serial line; idle high.
//   busy_o      out  1       1 in any state other than IDLE.
//   done_o      out  1       One-cycle pulse on the last cycle of the stop bit.
// BEHAVIOUR
//   Reset: state=IDLE, tx_o=1, q_En_o=0, q_RW_o=0, busy_o=0, done_o=0.
//     Shift register, bit counter and baud counter are cleared.
//   FSM states: IDLE, REQ, CAPT, START, DATA, PAR, STOP.
//   - IDLE: if Tx_En_i && !q_empty_i -> REQ; otherwise stay in IDLE.
//   - REQ (1 cycle): q_En_o=1, q_RW_o=1 -> CAPT.
//   - CAPT (1 cycle): shreg <= q_data_i; parity <= ^q_data_i -> START.
//     The baud counter is cleared on entry to START.
//   - START: tx_o=0 for CLKS_PER_BIT cycles -> DATA.
//   - DATA: tx_o=shreg[0]; shift right at the end of each bit.
//     After DATA_W bits -> PAR if PARITY_EN, else -> STOP.
//   - PAR: tx_o=parity for CLKS_PER_BIT cycles -> STOP.
//   - STOP: tx_o=1 for CLKS_PER_BIT cycles; done_o=1 on the last cycle.
//     Then -> REQ if Tx_En_i && !q_empty_i, else -> IDLE.
//   Outputs: tx_o is registered (glitch-free); 0 cycles to the line from state entry.
//   Latency: start bit first drives tx_o 2 cycles after the IDLE->REQ decision.
//   Back-to-back bytes: 2 idle-high cycles (REQ, CAPT) between stop and next start.
//   Frame length: (1 + DATA_W + PARITY_EN + 1) * CLKS_PER_BIT cycles.
//   Empty handling:
//     - q_empty_i is sampled only in IDLE and in the last cycle of STOP.
//     - A read is never issued while empty, so Queue underflow cannot occur.
//   Tx_En_i deasserted mid-frame: the current frame completes, then the FSM
//     goes to IDLE. No partial frames are ever sent.
//   Rst_i mid-frame: next edge forces IDLE and tx_o=1; the popped byte is dropped.
//     If reset coincides with REQ, the strobe is already issued and that byte is lost.
//   Baud counter wraps 0..CLKS_PER_BIT-1; bit counter width is $clog2(DATA_W+1).
// STRUCTURE
//   Shared package queue_if_pkg:
//     - state enum (IDLE..STOP)
//     - localparam RW_READ=1'b1, RW_WRITE=1'b0
//     - localparam IDLE_LEVEL=1'b1
//   Sub-module baud_tick_gen (param CLKS_PER_BIT):
//     - inputs: clr; outputs: tick on the last cycle of each bit.
//   Top level holds the FSM, shift register and parity register.
// TESTING  (CLKS_PER_BIT=4 unless stated; bench models Queue 1-cycle read data)
//   1. Reset with q_empty_i=0, Tx_En_i=1 -> tx_o=1, q_En_o=0 throughout reset.
//      First REQ occurs 1 cycle after Rst_i falls.
//   2. Queue holds 8'd115 (0x73), PARITY_EN=0 -> one q_En_o pulse with q_RW_o=1.
//      tx_o = 0,1,1,0,0,1,1,1,0,1, each held 4 cycles (40 cycles total).
//      done_o pulses once; busy_o then drops.
//   3. Queue holds 115 then 123, PARITY_EN=1 -> frame 1 parity bit = 1.
//      Exactly 2 idle-high cycles, then frame 2 = 0,1,1,0,1,1,1,1,0,0,1
//      (parity 0); 2 q_En_o pulses total.
//   4. q_empty_i=1 for 100 cycles with Tx_En_i=1 -> q_En_o never asserts.
//      tx_o stays 1 and busy_o=0.
//   5. Tx_En_i dropped during D3 of a frame -> the frame completes to its stop bit.
//      No further q_En_o although q_empty_i=0.
//   6. Rst_i pulsed 1 cycle during D5 -> tx_o=1 and busy_o=0 on the next edge.
//      The next frame restarts cleanly with a fresh REQ.

Source files
------------

// File: rtl/queue_if_pkg.sv
// Shared definitions for the Queue read-side consumer: FSM states and
// the bus/line levels used on the Queue and serial interfaces.
package queue_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPT,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter. tick marks the last cycle of a bit,
// pre_tick the cycle before it; clr restarts the period at count 0.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == LAST);
  assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/queue_drain_tx.sv
// Drains bytes from a Queue via single-cycle read strobes and sends each one
// as an LSB-first async frame: start, data, optional even parity, stop.
module queue_drain_tx
  import queue_if_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int DATA_W       = 8
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Tx_En_i,
  input  logic              q_empty_i,
  input  logic [DATA_W-1:0] q_data_i,
  output logic              q_RW_o,
  output logic              q_En_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              parity;
  logic [BCW-1:0]    bit_cnt;
  logic              tick;
  logic              pre_tick;
  logic              baud_clr;
  logic              start_ok;

  // Clearing during CAPT aligns the first bit period with entry to START.
  assign baud_clr  = Rst_i || (state == CAPT);
  assign start_ok  = Tx_En_i && !q_empty_i;
  assign shreg_nxt = shreg >> 1;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (Clk_i),
    .clr     (baud_clr),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state   <= IDLE;
      tx_o    <= IDLE_LEVEL;
      q_En_o  <= 1'b0;
      q_RW_o  <= RW_WRITE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      shreg   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      q_En_o <= 1'b0;
      q_RW_o <= RW_WRITE;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= REQ;
            q_En_o <= 1'b1;
            q_RW_o <= RW_READ;
            busy_o <= 1'b1;
          end
        end
        REQ: begin
          state <= CAPT;
        end
        CAPT: begin
          shreg   <= q_data_i;
          parity  <= ^q_data_i;
          bit_cnt <= '0;
          tx_o    <= 1'b0;
          state   <= START;
        end
        START: begin
          if (tick) begin
            tx_o  <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg_nxt;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx_o  <= parity;
                state <= PAR;
              end else begin
                tx_o  <= IDLE_LEVEL;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= shreg_nxt[0];
            end
          end
        end
        PAR: begin
          if (tick) begin
            tx_o  <= IDLE_LEVEL;
            state <= STOP;
          end
        end
        STOP: begin
          // done_o is registered, so it is raised one cycle ahead of the tick.
          if (pre_tick) begin
            done_o <= 1'b1;
          end
          if (tick) begin
            if (start_ok) begin
              state  <= REQ;
              q_En_o <= 1'b1;
              q_RW_o <= RW_READ;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_drain_tx.sv
// Bench for queue_drain_tx: one instance without parity, one with even parity,
// a Queue model with one-cycle read data, and a per-cycle expected-line queue.
module tb_queue_drain_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       sel = 1'b0;
  logic       q_empty = 1'b1;
  logic [7:0] q_data = 8'h00;

  logic rw0, en0, tx0, busy0, done0;
  logic rw1, en1, tx1, busy1, done1;
  logic m_rw, m_en, m_tx, m_busy, m_done;

  logic [7:0] model_q[$];
  logic [2:0] exp_q[$];  // {busy, done, tx} per cycle

  int n_cmp = 0;
  int n_fail = 0;
  int en_pulses = 0;

  always #5 clk = ~clk;

  queue_drain_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .DATA_W(8)) dut0 (
    .Clk_i(clk), .Rst_i(rst), .Tx_En_i(tx_en && !sel), .q_empty_i(q_empty),
    .q_data_i(q_data), .q_RW_o(rw0), .q_En_o(en0), .tx_o(tx0),
    .busy_o(busy0), .done_o(done0)
  );

  queue_drain_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .DATA_W(8)) dut1 (
    .Clk_i(clk), .Rst_i(rst), .Tx_En_i(tx_en && sel), .q_empty_i(q_empty),
    .q_data_i(q_data), .q_RW_o(rw1), .q_En_o(en1), .tx_o(tx1),
    .busy_o(busy1), .done_o(done1)
  );

  assign m_rw   = sel ? rw1   : rw0;
  assign m_en   = sel ? en1   : en0;
  assign m_tx   = sel ? tx1   : tx0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;

  // Queue model: data appears during the cycle after the strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (m_en === 1'b1) begin
        n_cmp++;
        if (m_rw !== 1'b1) begin
          n_fail++;
          $display("FAIL rw_on_strobe: got %b want 1", m_rw);
        end
        n_cmp++;
        if (model_q.size() == 0) begin
          n_fail++;
          $display("FAIL underflow: strobe got 1 want 0 (queue empty)");
        end else begin
          q_data = model_q.pop_front();
        end
        en_pulses++;
      end
      q_empty = (model_q.size() == 0);
    end
  end

  task automatic push_frame(input logic [7:0] b, input bit par);
    logic [10:0] bits;
    int n;
    n = par ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    if (par) bits[9] = ^b;
    bits[n-1] = 1'b1;
    repeat (2) exp_q.push_back(3'b101);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_q.push_back({1'b1, (k == n - 1) && (c == CPB - 1), bits[k]});
      end
    end
  endtask

  // Aligns on the read strobe, then compares every cycle against exp_q.
  task automatic run_check(input int budget);
    int t;
    bit first;
    logic [2:0] exp;
    t = 0;
    while (m_en !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (m_en !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_timeout: got no strobe want one within %0d cycles", budget);
      exp_q.delete();
      return;
    end
    first = 1'b1;
    while (exp_q.size() > 0) begin
      if (!first) @(negedge clk);
      first = 1'b0;
      exp = exp_q.pop_front();
      n_cmp++;
      if ({m_busy, m_done, m_tx} !== exp) begin
        n_fail++;
        $display("FAIL frame_cycle: got busy/done/tx=%b want %b", {m_busy, m_done, m_tx}, exp);
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    model_q.push_back(8'd115);
    rst = 1'b1;
    tx_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({m_tx, m_en, m_rw, m_busy, m_done} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_outputs: got tx/en/rw/busy/done=%b want 10000",
                 {m_tx, m_en, m_rw, m_busy, m_done});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_en !== 1'b1) begin
      n_fail++;
      $display("FAIL first_req: got q_En_o=%b want 1", m_en);
    end
  endtask

  task automatic test_single_frame();
    push_frame(8'd115, 1'b0);
    run_check(5);
    @(negedge clk);
    n_cmp++;
    if ({m_busy, m_tx} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_idle: got busy/tx=%b want 01", {m_busy, m_tx});
    end
    n_cmp++;
    if (en_pulses !== 1) begin
      n_fail++;
      $display("FAIL single_strobes: got %0d want 1", en_pulses);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    tx_en = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    base = en_pulses;
    model_q.push_back(8'd115);
    model_q.push_back(8'd123);
    push_frame(8'd115, 1'b1);
    push_frame(8'd123, 1'b1);
    tx_en = 1'b1;
    run_check(10);
    @(negedge clk);
    n_cmp++;
    if ({m_busy, m_tx} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy/tx=%b want 01", {m_busy, m_tx});
    end
    n_cmp++;
    if (en_pulses - base !== 2) begin
      n_fail++;
      $display("FAIL b2b_strobes: got %0d want 2", en_pulses - base);
    end
    tx_en = 1'b0;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_empty();
    int base;
    int bad_tx;
    int bad_busy;
    base = en_pulses;
    bad_tx = 0;
    bad_busy = 0;
    tx_en = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (m_tx !== 1'b1) bad_tx++;
      if (m_busy !== 1'b0) bad_busy++;
    end
    n_cmp++;
    if (en_pulses - base !== 0) begin
      n_fail++;
      $display("FAIL empty_strobes: got %0d want 0", en_pulses - base);
    end
    n_cmp++;
    if (bad_tx !== 0) begin
      n_fail++;
      $display("FAIL empty_tx: got %0d non-idle cycles want 0", bad_tx);
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_fail++;
      $display("FAIL empty_busy: got %0d busy cycles want 0", bad_busy);
    end
  endtask

  task automatic test_en_drop();
    int base;
    base = en_pulses;
    model_q.push_back(8'hA5);
    model_q.push_back(8'h3C);
    push_frame(8'hA5, 1'b0);
    tx_en = 1'b1;
    fork
      run_check(10);
      begin : dropper
        int t;
        t = 0;
        while (m_en !== 1'b1 && t < 10) begin
          @(negedge clk);
          t++;
        end
        repeat (2 + CPB * 4 + 1) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    n_cmp++;
    if (en_pulses - base !== 1) begin
      n_fail++;
      $display("FAIL drop_strobes: got %0d want 1", en_pulses - base);
    end
    n_cmp++;
    if ({m_busy, m_tx} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_idle: got busy/tx=%b want 01", {m_busy, m_tx});
    end
    n_cmp++;
    if (model_q.size() !== 1) begin
      n_fail++;
      $display("FAIL drop_queue_left: got %0d want 1", model_q.size());
    end
    model_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t;
    model_q.push_back(8'h5A);
    tx_en = 1'b1;
    t = 0;
    while (m_en !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (m_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_strobe: got %b want 1", m_en);
    end
    repeat (2 + CPB * 6 + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_busy, m_tx, m_en} !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_reset: got busy/tx/en=%b want 010", {m_busy, m_tx, m_en});
    end
    rst = 1'b0;
    model_q.push_back(8'hC3);
    push_frame(8'hC3, 1'b0);
    run_check(10);
    @(negedge clk);
    n_cmp++;
    if ({m_busy, m_tx} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_restart_idle: got busy/tx=%b want 01", {m_busy, m_tx});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_empty();
    test_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
